// File: rtl/rpspmc_axis_pkg.sv
// Shared definitions for the RPSPMC AXIS adder/splitter family:
// re-centring FSM states, saturation helper and coarse range derivation.
package rpspmc_axis_pkg;

   typedef enum logic [1:0] {
      ST_TRACK      = 2'd0,
      ST_SHIFT_UP   = 2'd1,
      ST_SHIFT_DOWN = 2'd2
   } ssplit_state_t;

   // Largest magnitude representable in a signed out_w-bit stream, kept symmetric.
   function automatic logic signed [63:0] coarse_max(input int unsigned out_w);
      return (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
   endfunction

   function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] value,
                                                    input logic signed [63:0] limit);
      logic signed [63:0] res;
      if (value > limit) begin
         res = limit;
      end else if (value < -limit) begin
         res = -limit;
      end else begin
         res = value;
      end
      return res;
   endfunction

endpackage

// File: rtl/ssplit_recentre_fsm.sv
// Re-centring controller: hysteresis FSM, slew divider and the clamped coarse offset c.
module ssplit_recentre_fsm
   import rpspmc_axis_pkg::*;
#(
   parameter int SAXIS_TDATA_WIDTH = 32,
   parameter int MAXIS_TDATA_WIDTH = 32,
   parameter int TRIGGER           = 12582912,
   parameter int TARGET            = 4194304,
   parameter int SHIFT_STEP        = 1048576,
   parameter int SLEW_DIV          = 4
) (
   input  logic                                i_clk,
   input  logic                                i_reset,
   input  logic                                i_load,
   input  logic signed [SAXIS_TDATA_WIDTH+1:0] i_d,
   output logic signed [SAXIS_TDATA_WIDTH+1:0] o_c,
   output logic                                o_shifting,
   output logic                                o_coarse_lim
);

   localparam int CW    = SAXIS_TDATA_WIDTH + 2;
   localparam int CNT_W = $clog2(SLEW_DIV + 1);

   localparam logic signed [CW-1:0] L_TRIG = CW'(TRIGGER);
   localparam logic signed [CW-1:0] L_TGT  = CW'(TARGET);
   localparam logic signed [CW-1:0] L_STEP = CW'(SHIFT_STEP);
   localparam logic signed [CW-1:0] L_CMAX = CW'(coarse_max(MAXIS_TDATA_WIDTH));
   localparam logic [CNT_W-1:0]     L_DIV  = CNT_W'(SLEW_DIV);

   ssplit_state_t          r_state, w_state_nxt;
   logic [CNT_W-1:0]       r_cnt, w_cnt_nxt, w_cnt_inc;
   logic signed [CW-1:0]   r_c, w_c_nxt, w_c_up, w_c_dn;
   logic                   r_shifting, r_lim, w_lim_nxt;

   assign w_cnt_inc = r_cnt + CNT_W'(1);
   // Compare before adding so the step can never leave the symmetric range.
   assign w_c_up    = (r_c > L_CMAX - L_STEP) ? L_CMAX : r_c + L_STEP;
   assign w_c_dn    = (r_c < L_STEP - L_CMAX) ? -L_CMAX : r_c - L_STEP;
   assign w_lim_nxt = ((w_state_nxt == ST_SHIFT_UP)   && (w_c_nxt == L_CMAX)) ||
                      ((w_state_nxt == ST_SHIFT_DOWN) && (w_c_nxt == -L_CMAX));

   // Next-state, slew counter and coarse step decision, only on a stage-2 load.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_c_nxt     = r_c;
      if (i_load) begin
         case (r_state)
            ST_TRACK: begin
               if (i_d > L_TRIG) begin
                  w_state_nxt = ST_SHIFT_UP;
                  w_cnt_nxt   = {CNT_W{1'b0}};
               end else if (i_d < -L_TRIG) begin
                  w_state_nxt = ST_SHIFT_DOWN;
                  w_cnt_nxt   = {CNT_W{1'b0}};
               end else begin
                  w_state_nxt = ST_TRACK;
               end
            end
            ST_SHIFT_UP: begin
               if (i_d < -L_TRIG) begin
                  w_state_nxt = ST_SHIFT_DOWN;
                  w_cnt_nxt   = {CNT_W{1'b0}};
               end else if (i_d <= L_TGT) begin
                  w_state_nxt = ST_TRACK;
                  w_cnt_nxt   = {CNT_W{1'b0}};
               end else if (w_cnt_inc == L_DIV) begin
                  w_cnt_nxt   = {CNT_W{1'b0}};
                  w_c_nxt     = w_c_up;
               end else begin
                  w_cnt_nxt   = w_cnt_inc;
               end
            end
            ST_SHIFT_DOWN: begin
               if (i_d > L_TRIG) begin
                  w_state_nxt = ST_SHIFT_UP;
                  w_cnt_nxt   = {CNT_W{1'b0}};
               end else if (i_d >= -L_TGT) begin
                  w_state_nxt = ST_TRACK;
                  w_cnt_nxt   = {CNT_W{1'b0}};
               end else if (w_cnt_inc == L_DIV) begin
                  w_cnt_nxt   = {CNT_W{1'b0}};
                  w_c_nxt     = w_c_dn;
               end else begin
                  w_cnt_nxt   = w_cnt_inc;
               end
            end
            default: begin
               w_state_nxt = ST_TRACK;
               w_cnt_nxt   = {CNT_W{1'b0}};
            end
         endcase
      end else begin
         w_state_nxt = r_state;
      end
   end

   // State, counter, coarse register and load-aligned status flags.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_TRACK;
         r_cnt      <= {CNT_W{1'b0}};
         r_c        <= {CW{1'b0}};
         r_shifting <= 1'b0;
         r_lim      <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_c     <= w_c_nxt;
         if (i_load) begin
            r_shifting <= (w_state_nxt != ST_TRACK);
            r_lim      <= w_lim_nxt;
         end
      end
   end

   assign o_c          = r_c;
   assign o_shifting   = r_shifting;
   assign o_coarse_lim = r_lim;

endmodule

// File: rtl/axis_ssplit.sv
// Saturating stream splitter: x -> coarse offset A plus bounded fine residual B,
// two-stage pipeline with the re-centring controller in a sub-module.
module axis_ssplit
   import rpspmc_axis_pkg::*;
#(
   parameter int SAXIS_TDATA_WIDTH = 32,
   parameter int MAXIS_TDATA_WIDTH = 32,
   parameter int FINE_LIMIT        = 16777216,
   parameter int TRIGGER           = 12582912,
   parameter int TARGET            = 4194304,
   parameter int SHIFT_STEP        = 1048576,
   parameter int SLEW_DIV          = 4
) (
   input  logic                         a_clk,
   input  logic                         a_reset,
   input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_X_tdata,
   input  logic                         S_AXIS_X_tvalid,
   output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_A_tdata,
   output logic                         M_AXIS_A_tvalid,
   output logic [MAXIS_TDATA_WIDTH-1:0] M_AXIS_B_tdata,
   output logic                         M_AXIS_B_tvalid,
   output logic                         shifting,
   output logic                         fine_sat,
   output logic                         coarse_lim
);

   localparam int CW = SAXIS_TDATA_WIDTH + 2;
   localparam int MW = MAXIS_TDATA_WIDTH;
   localparam logic signed [63:0] L_FINE = 64'(FINE_LIMIT);

   logic signed [CW-1:0] r_x1, r_c1, w_d, w_c;
   logic                 r_v1, r_v2, r_fsat, w_fsat;
   logic [MW-1:0]        r_a, r_b;
   logic signed [63:0]   w_d64, w_b64;

   // Full-width difference: x and c both fit in CW-1 bits, so no overflow.
   assign w_d    = r_x1 - r_c1;
   assign w_d64  = 64'(w_d);
   assign w_b64  = sat_clamp(w_d64, L_FINE);
   assign w_fsat = (w_d64 > L_FINE) || (w_d64 < -L_FINE);

   // Stage 1: capture sample and the coarse snapshot it will be split against.
   always_ff @(posedge a_clk) begin
      if (a_reset) begin
         r_x1 <= {CW{1'b0}};
         r_c1 <= {CW{1'b0}};
         r_v1 <= 1'b0;
      end else begin
         r_v1 <= S_AXIS_X_tvalid;
         if (S_AXIS_X_tvalid) begin
            r_x1 <= CW'($signed(S_AXIS_X_tdata));
            r_c1 <= w_c;
         end
      end
   end

   // Stage 2: output beat; data and fine_sat hold across input gaps.
   always_ff @(posedge a_clk) begin
      if (a_reset) begin
         r_v2   <= 1'b0;
         r_a    <= {MW{1'b0}};
         r_b    <= {MW{1'b0}};
         r_fsat <= 1'b0;
      end else begin
         r_v2 <= r_v1;
         if (r_v1) begin
            r_a    <= MW'(r_c1);
            r_b    <= MW'(w_b64);
            r_fsat <= w_fsat;
         end
      end
   end

   ssplit_recentre_fsm #(
      .SAXIS_TDATA_WIDTH (SAXIS_TDATA_WIDTH),
      .MAXIS_TDATA_WIDTH (MAXIS_TDATA_WIDTH),
      .TRIGGER           (TRIGGER),
      .TARGET            (TARGET),
      .SHIFT_STEP        (SHIFT_STEP),
      .SLEW_DIV          (SLEW_DIV)
   ) u_recentre (
      .i_clk        (a_clk),
      .i_reset      (a_reset),
      .i_load       (r_v1),
      .i_d          (w_d),
      .o_c          (w_c),
      .o_shifting   (shifting),
      .o_coarse_lim (coarse_lim)
   );

   assign M_AXIS_A_tdata  = r_a;
   assign M_AXIS_B_tdata  = r_b;
   assign M_AXIS_A_tvalid = r_v2;
   assign M_AXIS_B_tvalid = r_v2;
   assign fine_sat        = r_fsat;

endmodule

// File: tb/tb_axis_ssplit.sv
// Randomized/directed bench for axis_ssplit: a default instance and a narrow-output
// instance (reachable coarse limit) share one stimulus and a per-beat reference model.
module tb_axis_ssplit;

   localparam longint P_FINE [2] = '{64'sd16777216, 64'sd1000000};
   localparam longint P_TRIG [2] = '{64'sd12582912, 64'sd600000};
   localparam longint P_TGT  [2] = '{64'sd4194304,  64'sd200000};
   localparam longint P_STEP [2] = '{64'sd1048576,  64'sd1048576};
   localparam longint P_DIV  [2] = '{64'sd4,        64'sd2};
   localparam longint P_CMAX [2] = '{64'sd2147483647, 64'sd8388607};

   logic        clk;
   logic        rst;
   logic [31:0] x_s;
   logic        xv_s;
   logic [31:0] a0, b0;
   logic [23:0] a1, b1;
   logic        va0, vb0, sh0, fs0, lim0;
   logic        va1, vb1, sh1, fs1, lim1;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state: dir is 0 (hold), +1 (raise c), -1 (lower c).
   longint m_c [2];
   int     m_dir [2];
   longint m_cnt [2];
   bit     pend_v;
   longint pend_x;
   longint pend_c [2];
   bit     e_v;
   longint e_a [2], e_b [2];
   bit     e_fs [2], e_sh [2], e_lim [2];

   axis_ssplit u_dut0 (
      .a_clk           (clk),
      .a_reset         (rst),
      .S_AXIS_X_tdata  (x_s),
      .S_AXIS_X_tvalid (xv_s),
      .M_AXIS_A_tdata  (a0),
      .M_AXIS_A_tvalid (va0),
      .M_AXIS_B_tdata  (b0),
      .M_AXIS_B_tvalid (vb0),
      .shifting        (sh0),
      .fine_sat        (fs0),
      .coarse_lim      (lim0)
   );

   axis_ssplit #(
      .SAXIS_TDATA_WIDTH (32),
      .MAXIS_TDATA_WIDTH (24),
      .FINE_LIMIT        (1000000),
      .TRIGGER           (600000),
      .TARGET            (200000),
      .SHIFT_STEP        (1048576),
      .SLEW_DIV          (2)
   ) u_dut1 (
      .a_clk           (clk),
      .a_reset         (rst),
      .S_AXIS_X_tdata  (x_s),
      .S_AXIS_X_tvalid (xv_s),
      .M_AXIS_A_tdata  (a1),
      .M_AXIS_A_tvalid (va1),
      .M_AXIS_B_tdata  (b1),
      .M_AXIS_B_tvalid (vb1),
      .shifting        (sh1),
      .fine_sat        (fs1),
      .coarse_lim      (lim1)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic recentre(input int i, input longint d);
      if (m_dir[i] == 0) begin
         if (d > P_TRIG[i]) begin
            m_dir[i] = 1;  m_cnt[i] = 0;
         end else if (d < -P_TRIG[i]) begin
            m_dir[i] = -1; m_cnt[i] = 0;
         end
      end else if (m_dir[i] * d < -P_TRIG[i]) begin
         m_dir[i] = -m_dir[i]; m_cnt[i] = 0;
      end else if (m_dir[i] * d <= P_TGT[i]) begin
         m_dir[i] = 0; m_cnt[i] = 0;
      end else begin
         m_cnt[i]++;
         if (m_cnt[i] == P_DIV[i]) begin
            m_cnt[i] = 0;
            m_c[i] = m_c[i] + m_dir[i] * P_STEP[i];
            if (m_c[i] > P_CMAX[i]) m_c[i] = P_CMAX[i];
            if (m_c[i] < -P_CMAX[i]) m_c[i] = -P_CMAX[i];
         end
      end
   endtask

   // One clock edge of the model: finish the beat split last cycle, accept this one.
   task automatic model_edge(input bit r, input bit v, input longint x);
      longint c_before [2];
      longint d;
      if (r) begin
         for (int i = 0; i < 2; i++) begin
            m_c[i] = 0; m_dir[i] = 0; m_cnt[i] = 0; pend_c[i] = 0;
            e_a[i] = 0; e_b[i] = 0; e_fs[i] = 0; e_sh[i] = 0; e_lim[i] = 0;
         end
         pend_v = 0; pend_x = 0; e_v = 0;
      end else begin
         for (int i = 0; i < 2; i++) c_before[i] = m_c[i];
         e_v = pend_v;
         if (pend_v) begin
            for (int i = 0; i < 2; i++) begin
               d = pend_x - pend_c[i];
               e_a[i]  = pend_c[i];
               e_b[i]  = (d > P_FINE[i]) ? P_FINE[i] : ((d < -P_FINE[i]) ? -P_FINE[i] : d);
               e_fs[i] = (d > P_FINE[i]) || (d < -P_FINE[i]);
               recentre(i, d);
               e_sh[i]  = (m_dir[i] != 0);
               e_lim[i] = (m_dir[i] != 0) && (m_c[i] == m_dir[i] * P_CMAX[i]);
            end
         end
         if (v) begin
            pend_x = x;
            for (int i = 0; i < 2; i++) pend_c[i] = c_before[i];
         end
         pend_v = v;
      end
   endtask

   task automatic compare_all();
      check_eq("a0", 64'($signed(a0)), e_a[0]);
      check_eq("b0", 64'($signed(b0)), e_b[0]);
      check_eq("va0", 64'(va0), 64'(e_v));
      check_eq("vb0", 64'(vb0), 64'(e_v));
      check_eq("fs0", 64'(fs0), 64'(e_fs[0]));
      check_eq("sh0", 64'(sh0), 64'(e_sh[0]));
      check_eq("lim0", 64'(lim0), 64'(e_lim[0]));
      check_eq("a1", 64'($signed(a1)), e_a[1]);
      check_eq("b1", 64'($signed(b1)), e_b[1]);
      check_eq("va1", 64'(va1), 64'(e_v));
      check_eq("vb1", 64'(vb1), 64'(e_v));
      check_eq("fs1", 64'(fs1), 64'(e_fs[1]));
      check_eq("sh1", 64'(sh1), 64'(e_sh[1]));
      check_eq("lim1", 64'(lim1), 64'(e_lim[1]));
   endtask

   task automatic cyc(input bit r, input bit v, input logic signed [31:0] x);
      rst  = r;
      xv_s = v;
      x_s  = x;
      @(posedge clk);
      model_edge(r, v, 64'(x));
      #1;
      compare_all();
   endtask

   initial begin
      int x_rand;
      clk  = 1'b0;
      rst  = 1'b1;
      xv_s = 1'b0;
      x_s  = 32'd0;

      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 32'sd0);

      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 32'sd1000);
      check_eq("small_a", 64'($signed(a0)), 64'sd0);
      check_eq("small_b", 64'($signed(b0)), 64'sd1000);
      check_eq("small_sh", 64'(sh0), 64'sd0);

      cyc(1'b0, 1'b1, 32'sd20000000);
      cyc(1'b0, 1'b1, 32'sd20000000);
      check_eq("up_first_b", 64'($signed(b0)), 64'sd16777216);
      check_eq("up_first_fs", 64'(fs0), 64'sd1);
      check_eq("up_first_sh", 64'(sh0), 64'sd1);
      for (int i = 0; i < 90; i++) cyc(1'b0, 1'b1, 32'sd20000000);
      check_eq("up_end_a", 64'($signed(a0)), 64'sd16777216);
      check_eq("up_end_b", 64'($signed(b0)), 64'sd3222784);
      check_eq("up_end_sh", 64'(sh0), 64'sd0);
      check_eq("n_lim_a", 64'($signed(a1)), 64'sd8388607);
      check_eq("n_lim_b", 64'($signed(b1)), 64'sd1000000);
      check_eq("n_lim_flag", 64'(lim1), 64'sd1);

      for (int i = 0; i < 160; i++) cyc(1'b0, 1'b1, -32'sd20000000);
      check_eq("dn_end_a", 64'($signed(a0)), -64'sd16777216);
      check_eq("dn_end_b", 64'($signed(b0)), -64'sd3222784);
      check_eq("n_lim_neg_a", 64'($signed(a1)), -64'sd8388607);
      check_eq("n_lim_neg_flag", 64'(lim1), 64'sd1);

      for (int i = 0; i < 300; i++) cyc(1'b0, (i % 2) == 0, 32'sd20000000);
      check_eq("gap_end_b", 64'($signed(b0)), 64'sd3222784);

      for (int i = 0; i < 8400; i++) cyc(1'b0, 1'b1, 32'sd2147483647);
      check_eq("max_a", 64'($signed(a0)), 64'sd2143289344);
      check_eq("max_b", 64'($signed(b0)), 64'sd4194303);
      check_eq("max_n_b", 64'($signed(b1)), 64'sd1000000);

      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(3, 0))
            0: x_rand = int'($urandom);
            1: x_rand = int'($urandom_range(60000000, 0)) - 30000000;
            2: x_rand = int'($urandom_range(10000000, 0)) - 5000000;
            default: x_rand = int'(x_s);
         endcase
         cyc($urandom_range(499, 0) == 0, $urandom_range(3, 0) != 0, x_rand);
      end

      cyc(1'b1, 1'b0, 32'sd0);
      cyc(1'b1, 1'b0, 32'sd0);
      for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 32'sd20000000);
      cyc(1'b1, 1'b1, 32'sd20000000);
      check_eq("rst_a", 64'($signed(a0)), 64'sd0);
      check_eq("rst_b", 64'($signed(b0)), 64'sd0);
      check_eq("rst_v", 64'(va0), 64'sd0);
      check_eq("rst_sh", 64'(sh0), 64'sd0);
      check_eq("rst_fs", 64'(fs0), 64'sd0);
      cyc(1'b0, 1'b1, 32'sd500);
      cyc(1'b0, 1'b1, 32'sd500);
      check_eq("post_rst_a", 64'($signed(a0)), 64'sd0);
      check_eq("post_rst_b", 64'($signed(b0)), 64'sd500);
      check_eq("post_rst_v", 64'(vb0), 64'sd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
